// File: rtl/pipe_memory_access.sv
// pipe_memory_access: M-stage req/ack memory controller with stall, timeout and MEM/WB register
module pipe_memory_access #(
  parameter int DATA_WIDTH  = 32,
  parameter int WRITE_WIDTH = 5,
  parameter int TIMEOUT     = 16,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   regwritem,
  input  logic [1:0]             resultsrcm,
  input  logic                   memwritem,
  input  logic [DATA_WIDTH-1:0]  aluresultm,
  input  logic [DATA_WIDTH-1:0]  writedatam,
  input  logic [WRITE_WIDTH-1:0] rdm,
  input  logic [DATA_WIDTH-1:0]  pcplus4m,
  output logic                   memreq,
  output logic                   memwe,
  output logic [DATA_WIDTH-1:0]  memaddr,
  output logic [DATA_WIDTH-1:0]  memwdata,
  input  logic [DATA_WIDTH-1:0]  memrdata,
  input  logic                   memack,
  output logic                   stallm,
  output logic                   buserr,
  output logic                   regwritew,
  output logic [1:0]             resultsrcw,
  output logic [DATA_WIDTH-1:0]  aluresultw,
  output logic [DATA_WIDTH-1:0]  readdataw,
  output logic [WRITE_WIDTH-1:0] rdw,
  output logic [DATA_WIDTH-1:0]  pcplus4w
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_next;
  logic [CNT_WIDTH-1:0] cnt, cnt_next;
  logic access, load, expired, forced, done;
  // Bus drive, stall decision and next state; stall lasts until ack or forced completion
  always_comb begin
    load       = resultsrcm == 2'b01;
    access     = memwritem | load;
    expired    = (TIMEOUT != 0) && (cnt == CNT_WIDTH'(TIMEOUT));
    forced     = (state == WAIT) & ~memack & expired;
    memreq     = rst_n & ((state == WAIT) | access);
    memwe      = memreq & memwritem;
    memaddr    = aluresultm;
    memwdata   = writedatam;
    done       = (state == WAIT) ? (memack | expired) : (~access | memack);
    stallm     = rst_n & ~done;
    state_next = stallm ? WAIT : IDLE;
    cnt_next   = stallm ? cnt + 1'b1 : '0;
  end
  // FSM state, wait counter, sticky timeout flag and W-stage register with bubble insertion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      buserr     <= 1'b0;
      regwritew  <= 1'b0;
      resultsrcw <= 2'b00;
      aluresultw <= '0;
      readdataw  <= '0;
      rdw        <= '0;
      pcplus4w   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (forced) buserr <= 1'b1;
      if (stallm) begin
        regwritew  <= 1'b0;
        resultsrcw <= 2'b00;
      end else begin
        regwritew  <= regwritem;
        resultsrcw <= resultsrcm;
        aluresultw <= aluresultm;
        rdw        <= rdm;
        pcplus4w   <= pcplus4m;
        readdataw  <= (load & ~forced) ? memrdata : '0;
      end
    end
  end
endmodule

// File: tb/tb_pipe_memory_access.sv
// tb_pipe_memory_access: randomized self-checking bench with a transaction-level reference model
module tb_pipe_memory_access;
  localparam int T = 4;
  logic clk = 0, rst_n = 0;
  logic regwritem = 0, memwritem = 0, memack = 0;
  logic [1:0] resultsrcm = 0;
  logic [31:0] aluresultm = 0, writedatam = 0, pcplus4m = 0, memrdata = 0;
  logic [4:0] rdm = 0;
  logic memreq, memwe, stallm, buserr, regwritew;
  logic [31:0] memaddr, memwdata, aluresultw, readdataw, pcplus4w;
  logic [1:0] resultsrcw;
  logic [4:0] rdw;
  int checks = 0, failures = 0;
  logic e_rw, e_buserr;
  logic [1:0] e_rs;
  logic [31:0] e_alu, e_pc, e_rdata;
  logic [4:0] e_rd;

  pipe_memory_access #(.DATA_WIDTH(32), .WRITE_WIDTH(5), .TIMEOUT(T), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .regwritem(regwritem), .resultsrcm(resultsrcm), .memwritem(memwritem),
    .aluresultm(aluresultm), .writedatam(writedatam), .rdm(rdm), .pcplus4m(pcplus4m),
    .memreq(memreq), .memwe(memwe), .memaddr(memaddr), .memwdata(memwdata), .memrdata(memrdata),
    .memack(memack), .stallm(stallm), .buserr(buserr), .regwritew(regwritew), .resultsrcw(resultsrcw),
    .aluresultw(aluresultw), .readdataw(readdataw), .rdw(rdw), .pcplus4w(pcplus4w)
  );

  always #5 clk = ~clk;

  task automatic model_clear;
    e_rw = 0; e_rs = 0; e_alu = 0; e_pc = 0; e_rdata = 0; e_rd = 0; e_buserr = 0;
  endtask

  task automatic run_txn(input logic rw, input logic [1:0] rs, input logic mw, input logic [31:0] a,
                         input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc,
                         input logic [31:0] rdat, input int lat);
    logic acc, ld, to, fin;
    int stalls, reqs, exp_stalls;
    ld = rs == 2'b01;
    acc = mw | ld;
    regwritem = rw; resultsrcm = rs; memwritem = mw; aluresultm = a; writedatam = wd; rdm = rd; pcplus4m = pc;
    stalls = 0; reqs = 0; fin = 0;
    for (int k = 0; k < 20 && !fin; k++) begin
      memack = acc && k == lat;
      memrdata = memack ? rdat : $urandom;
      #1;
      checks++;
      if (memreq !== acc || (acc && (memwe !== mw || memaddr !== a || memwdata !== wd))) begin
        failures++;
        $display("FAIL bus k=%0d got req=%b we=%b addr=%h wdata=%h want req=%b we=%b addr=%h wdata=%h",
                 k, memreq, memwe, memaddr, memwdata, acc, mw, a, wd);
      end
      if (memreq === 1'b1) reqs++;
      fin = stallm !== 1'b1;
      if (!fin) stalls++;
      @(posedge clk); #1;
      if (!fin) begin
        checks++;
        if (regwritew !== 1'b0 || resultsrcw !== 2'b00 || aluresultw !== e_alu) begin
          failures++;
          $display("FAIL bubble k=%0d got rw=%b rs=%b alu=%h want rw=0 rs=00 alu=%h", k, regwritew, resultsrcw, aluresultw, e_alu);
        end
      end
    end
    memack = 0;
    exp_stalls = !acc ? 0 : (lat <= T ? lat : T);
    to = acc && lat > T;
    e_rw = rw; e_rs = rs; e_alu = a; e_rd = rd; e_pc = pc;
    e_rdata = (ld && !to) ? rdat : 32'h0;
    e_buserr = e_buserr | to;
    checks++;
    if (stalls != exp_stalls || reqs != (acc ? exp_stalls + 1 : 0)) begin
      failures++;
      $display("FAIL stall_count got stalls=%0d reqs=%0d want stalls=%0d reqs=%0d", stalls, reqs, exp_stalls, acc ? exp_stalls + 1 : 0);
    end
    checks++;
    if (regwritew !== e_rw || resultsrcw !== e_rs || aluresultw !== e_alu || rdw !== e_rd ||
        pcplus4w !== e_pc || readdataw !== e_rdata) begin
      failures++;
      $display("FAIL wcapture got rw=%b rs=%b alu=%h rd=%0d pc=%h rdata=%h want rw=%b rs=%b alu=%h rd=%0d pc=%h rdata=%h",
               regwritew, resultsrcw, aluresultw, rdw, pcplus4w, readdataw, e_rw, e_rs, e_alu, e_rd, e_pc, e_rdata);
    end
    checks++;
    if (buserr !== e_buserr) begin
      failures++;
      $display("FAIL buserr got %b want %b", buserr, e_buserr);
    end
  endtask

  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({regwritew, resultsrcw, aluresultw, readdataw, rdw, pcplus4w} !== '0 || memreq !== 0 || stallm !== 0 || buserr !== 0) begin
      failures++;
      $display("FAIL reset got rw=%b rs=%b alu=%h rdata=%h rd=%0d pc=%h req=%b stall=%b err=%b want all 0",
               regwritew, resultsrcw, aluresultw, readdataw, rdw, pcplus4w, memreq, stallm, buserr);
    end
    rst_n = 1;
    model_clear();
  endtask

  task automatic test_alu;
    run_txn(1, 2'b00, 0, 32'h10, 32'h0, 5'd5, 32'h1004, 32'h0, 0);
  endtask

  task automatic test_zero_wait_load;
    run_txn(1, 2'b01, 0, 32'h100, 32'h0, 5'd7, 32'h2008, 32'hDEADBEEF, 0);
  endtask

  task automatic test_store_wait;
    run_txn(0, 2'b00, 1, 32'h340, 32'hCAFE, 5'd0, 32'h300C, 32'h5555AAAA, 3);
  endtask

  task automatic test_timeout;
    run_txn(1, 2'b01, 0, 32'h480, 32'h0, 5'd9, 32'h4010, 32'h77777777, 100);
    run_txn(1, 2'b00, 0, 32'h55, 32'h0, 5'd3, 32'h4014, 32'h0, 0);
  endtask

  task automatic test_reset_in_wait;
    regwritem = 1; resultsrcm = 2'b01; memwritem = 0; aluresultm = 32'h200; rdm = 5'd11; pcplus4m = 32'h5000; memack = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (stallm !== 1'b1 || memreq !== 1'b1) begin
      failures++;
      $display("FAIL wait_pending got stall=%b req=%b want stall=1 req=1", stallm, memreq);
    end
    rst_n = 0;
    #1;
    checks++;
    if (memreq !== 1'b0 || stallm !== 1'b0) begin
      failures++;
      $display("FAIL reset_drop got req=%b stall=%b want req=0 stall=0", memreq, stallm);
    end
    @(posedge clk); #1;
    rst_n = 1; regwritem = 0; resultsrcm = 2'b00; memack = 1; memrdata = 32'h12345678;
    #1;
    checks++;
    if (memreq !== 1'b0 || stallm !== 1'b0) begin
      failures++;
      $display("FAIL late_ack got req=%b stall=%b want req=0 stall=0", memreq, stallm);
    end
    @(posedge clk); #1;
    memack = 0;
    checks++;
    if (readdataw !== 32'h0 || regwritew !== 1'b0 || buserr !== 1'b0 || aluresultw !== 32'h200) begin
      failures++;
      $display("FAIL after_reset got rdata=%h rw=%b err=%b alu=%h want rdata=0 rw=0 err=0 alu=00000200",
               readdataw, regwritew, buserr, aluresultw);
    end
    model_clear();
    e_alu = 32'h200; e_rd = 5'd11; e_pc = 32'h5000;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: run_txn($urandom_range(0, 1), 2'b00, 0, $urandom, $urandom, $urandom_range(0, 31), $urandom, $urandom, 0);
        1: run_txn($urandom_range(0, 1), 2'b10, 0, $urandom, $urandom, $urandom_range(0, 31), $urandom, $urandom, 0);
        2: run_txn(1, 2'b01, 0, $urandom, $urandom, $urandom_range(0, 31), $urandom, $urandom, $urandom_range(0, 6));
        default: run_txn(0, 2'b00, 1, $urandom, $urandom, $urandom_range(0, 31), $urandom, $urandom, $urandom_range(0, 6));
      endcase
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_alu();
    test_zero_wait_load();
    test_store_wait();
    test_timeout();
    test_reset_in_wait();
    test_back_to_back();
    test_reset();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
